shifter_operand: RTL and testbench



---
 rtl/shifter_operand.sv | 117 +++++++++++
 tb/tb_shifter_operand.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shifter_operand.sv
// Iterative shifter-operand unit: produces the ALU B operand and shifter carry
// from the operand-2 field, one shift/rotate step per clock.
module shifter_operand (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_imm_mode,
  input  logic [11:0] i_op2_field,
  input  logic [31:0] i_rm_val,
  input  logic        i_cin,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_op2,
  output logic        o_cout
);

  // state   | meaning
  // S_IDLE  | waiting for start; result of last operation held
  // S_SHIFT | one step per clock until cnt reaches 0
  // S_DONE  | result valid, done pulsed for one cycle
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {K_LSL, K_LSR, K_ASR, K_ROR, K_RRX} kind_t;

  state_t      r_state;
  kind_t       r_kind;
  logic [31:0] r_w;
  logic        r_c;
  logic [5:0]  r_cnt;

  kind_t       w_ld_kind;
  logic [5:0]  w_ld_cnt;
  logic [31:0] w_ld_w;
  logic [4:0]  w_amt;
  logic [31:0] w_nxt_w;
  logic        w_nxt_c;

  always_comb begin
    w_amt     = i_op2_field[11:7];
    w_ld_kind = K_ROR;
    w_ld_cnt  = {1'b0, i_op2_field[11:8], 1'b0};
    w_ld_w    = {24'b0, i_op2_field[7:0]};
    if (!i_imm_mode) begin
      w_ld_w = i_rm_val;
      case (i_op2_field[6:5])
        2'b00: begin
          w_ld_kind = K_LSL;
          w_ld_cnt  = {1'b0, w_amt};
        end
        2'b01: begin
          w_ld_kind = K_LSR;
          w_ld_cnt  = (w_amt == 5'd0) ? 6'd32 : {1'b0, w_amt};
        end
        2'b10: begin
          w_ld_kind = K_ASR;
          w_ld_cnt  = (w_amt == 5'd0) ? 6'd32 : {1'b0, w_amt};
        end
        default: begin
          // ROR #0 encodes RRX: a single 33-bit rotate through carry
          w_ld_kind = (w_amt == 5'd0) ? K_RRX : K_ROR;
          w_ld_cnt  = (w_amt == 5'd0) ? 6'd1 : {1'b0, w_amt};
        end
      endcase
    end
  end

  always_comb begin
    w_nxt_w = r_w;
    w_nxt_c = r_w[0];
    case (r_kind)
      K_LSL: begin
        w_nxt_c = r_w[31];
        w_nxt_w = {r_w[30:0], 1'b0};
      end
      K_LSR:   w_nxt_w = {1'b0, r_w[31:1]};
      K_ASR:   w_nxt_w = {r_w[31], r_w[31:1]};
      K_ROR:   w_nxt_w = {r_w[0], r_w[31:1]};
      K_RRX:   w_nxt_w = {r_c, r_w[31:1]};
      default: w_nxt_w = r_w;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_kind  <= K_LSL;
      r_w     <= 32'd0;
      r_c     <= 1'b0;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_kind  <= w_ld_kind;
            r_w     <= w_ld_w;
            r_c     <= i_cin;
            r_cnt   <= w_ld_cnt;
            r_state <= (w_ld_cnt == 6'd0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_w   <= w_nxt_w;
          r_c   <= w_nxt_c;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_op2  = r_w;
  assign o_cout = r_c;

endmodule

// File: tb/tb_shifter_operand.sv
// Directed bench for shifter_operand: hand-computed results, latency and
// handshake checks, plus start-while-busy and mid-shift reset cases.
module tb_shifter_operand;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        imm_mode;
  logic [11:0] op2_field;
  logic [31:0] rm_val;
  logic        cin;
  logic        busy;
  logic        done;
  logic [31:0] op2;
  logic        cout;

  int n_checks = 0;
  int n_fails  = 0;

  shifter_operand dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_imm_mode  (imm_mode),
    .i_op2_field (op2_field),
    .i_rm_val    (rm_val),
    .i_cin       (cin),
    .o_busy      (busy),
    .o_done      (done),
    .o_op2       (op2),
    .o_cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // poke_shift: cycle index (after E0) at which start is pulsed while busy
  // poke_done : also hold start high during the done cycle
  task automatic run(input string tag, input logic imm, input logic [11:0] fld,
                     input logic [31:0] rm, input logic ci,
                     input logic [31:0] exp_op2, input logic exp_cout,
                     input int exp_n, input int poke_shift, input bit poke_done);
    int cyc;
    int busy_low;
    @(negedge clk);
    imm_mode  = imm;
    op2_field = fld;
    rm_val    = rm;
    cin       = ci;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      if (cyc == poke_shift) begin
        start     = 1'b1;
        imm_mode  = 1'b1;
        op2_field = 12'h0AB;
        rm_val    = 32'hDEADBEEF;
        cin       = ~ci;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, " latency"}, cyc, exp_n + 1);
    chk({tag, " busy_low_cycles"}, busy_low + (busy ? 0 : 1), 0);
    chk({tag, " op2"}, op2, exp_op2);
    chk({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
    start = poke_done;
    if (poke_done) begin
      imm_mode  = 1'b1;
      op2_field = 12'h0AB;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " idle_done"}, {31'd0, done}, 32'd0);
    chk({tag, " hold_op2"}, op2, exp_op2);
  endtask

  initial begin
    int done_cnt;
    rst_n     = 1'b0;
    start     = 1'b0;
    imm_mode  = 1'b0;
    op2_field = 12'h000;
    rm_val    = 32'h0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst op2", op2, 32'd0);
    chk("rst cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run("imm_rot8",  1'b1, 12'h4FF, 32'h0,        1'b0, 32'hFF000000, 1'b1, 8,  -1, 1'b0);
    run("lsl4",      1'b0, 12'h200, 32'h1000000F, 1'b0, 32'h000000F0, 1'b1, 4,  -1, 1'b0);
    run("lsr32",     1'b0, 12'h020, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 32, -1, 1'b0);
    run("asr1",      1'b0, 12'h0C0, 32'h80000003, 1'b0, 32'hC0000001, 1'b1, 1,  -1, 1'b0);
    run("asr32",     1'b0, 12'h040, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 32, -1, 1'b0);
    run("rrx",       1'b0, 12'h060, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1,  -1, 1'b1);
    run("imm_rot0",  1'b1, 12'h0AB, 32'h0,        1'b1, 32'h000000AB, 1'b1, 0,  -1, 1'b0);
    run("lsl0",      1'b0, 12'h000, 32'h12345678, 1'b1, 32'h12345678, 1'b1, 0,  -1, 1'b0);
    run("ror4",      1'b0, 12'h260, 32'h0000001F, 1'b0, 32'hF0000001, 1'b1, 4,  -1, 1'b0);
    run("lsl4_poke", 1'b0, 12'h200, 32'h1000000F, 1'b0, 32'h000000F0, 1'b1, 4,  2,  1'b0);

    // reset in the middle of a long shift
    @(negedge clk);
    imm_mode  = 1'b0;
    op2_field = 12'h020;
    rm_val    = 32'hFFFFFFFF;
    cin       = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst op2", op2, 32'd0);
    chk("midrst cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    chk("midrst no_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
